// File: rtl/key_encoder.sv
// -----------------------------------------------------------------------------
// key_encoder
//
// Reads eight active-low push keys and turns each debounced press into a 3-bit
// key index for the control logic.
//
// Each key is synchronised by two flops and then debounced. A debounced 1->0
// transition is a press. While enable is high, a press sets that key's bit in
// the pending mask. Pending presses are presented one at a time, lowest index
// first, on a valid/ready handshake. If a key is pressed again while its bit is
// still pending, the new press is not queued and overrun pulses instead.
//
// Ports
//   clk      in   1  clock, all logic on the rising edge
//   rst      in   1  synchronous reset, active-high
//   enable   in   1  1 = capture new presses into pending, 0 = ignore presses
//   keys_n   in   8  raw key pins, active-low, asynchronous to clk
//   ready    in   1  consumer takes code when valid && ready at a rising edge
//   code     out  3  index of the key being presented (0 = keys_n[0])
//   valid    out  1  code holds a pending press
//   keys_db  out  8  debounced key state, active-low
//   overrun  out  1  one-cycle pulse: press on a key that was already pending
// -----------------------------------------------------------------------------
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] keys_n,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] keys_db,
  output logic       overrun
);

  localparam int NUM_KEYS = 8;
  localparam int CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the values from before the edge. That is what makes
  // s1 -> s2 a real two-stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= keys_n;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. cnt[i] counts consecutive cycles in which s2[i] differs from
  // keys_db[i]. The new level is accepted on the DEBOUNCE_CYCLES-th such
  // cycle. A bounce back to the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt [NUM_KEYS];

  // NOTE: cnt is a small array of flops, not a RAM, so it is reset with
  // everything else. A debounce run left half-finished before reset must not
  // leak into the first press after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_db <= '1;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (s2[i] == keys_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          keys_db[i] <= s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press detect and pending mask.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] db_prev;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] clr_mask;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pending_next;
  logic                overrun_next;

  // Only 1 -> 0 transitions are presses. Releases are ignored.
  assign fall  = db_prev & ~keys_db;
  assign press = fall & {NUM_KEYS{enable}};

  // NOTE: every signal written in an always_comb gets a default value first.
  // Then no path through the block leaves it unassigned, and no latch is
  // inferred.
  always_comb begin
    clr_mask = '0;
    if (valid && ready) clr_mask = NUM_KEYS'(1) << code;
    // A press on a key whose handshake happens on this same edge is kept:
    // the OR with press comes after the clear, so set wins.
    pending_next = (pending & ~clr_mask) | press;
    overrun_next = |(press & pending & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_prev <= '1;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      db_prev <= keys_db;
      pending <= pending_next;
      overrun <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select: the lowest set index of pending.
  // ---------------------------------------------------------------------------
  logic [2:0] low_idx;

  always_comb begin
    low_idx = '0;
    // Scan from the top down so that the lowest set bit is written last.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = 3'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM. In HOLD, code stays frozen until its handshake, so a later
  // lower-index press cannot pre-empt it. After a handshake the FSM always
  // returns to IDLE, so valid is low for at least one cycle between codes.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [2:0] code_next;
  logic       valid_next;

  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = valid;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (|pending) begin
          code_next  = low_idx;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code  <= 3'd0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      code  <= code_next;
      valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_encoder
//
// Directed bench for key_encoder with DEBOUNCE_CYCLES = 4.
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled on
// the falling edge. Every press that should produce a code pushes that code
// onto exp_q. A monitor pops exp_q whenever it sees valid && ready and
// compares the popped value with code. The monitor also checks that code and
// valid stay stable while a code is held, and it counts overrun pulses.
// -----------------------------------------------------------------------------
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] keys_n;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] keys_db;
  logic       overrun;

  key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .keys_n  (keys_n),
    .ready   (ready),
    .code    (code),
    .valid   (valid),
    .keys_db (keys_db),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int pushes      = 0;
  int handshakes  = 0;
  int overrun_cnt = 0;
  int db5_falls   = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_code(input int c);
    exp_q.push_back(c);
    pushes++;
  endtask

  // Waits, for a bounded number of cycles, until every expected code has
  // been delivered.
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor and scoreboard.
  // ---------------------------------------------------------------------------
  logic       hold_prev = 1'b0;
  logic [2:0] prev_code = 3'd0;
  logic       prev_ovr  = 1'b0;
  logic [7:0] prev_db   = 8'hff;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      prev_ovr  = 1'b0;
      prev_db   = 8'hff;
    end else begin
      if (hold_prev) begin
        check("valid_held", valid, 1);
        check("code_stable", code, prev_code);
      end
      if (overrun) begin
        overrun_cnt++;
        check("overrun_one_cycle", prev_ovr, 0);
      end
      prev_ovr = overrun;
      if (prev_db[5] && !keys_db[5]) db5_falls++;
      prev_db = keys_db;
      if (valid && ready) begin
        handshakes++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_code: observed code %0d expected no delivery", code);
        end
        if (exp_q.size() != 0) check("code", code, exp_q.pop_front());
      end
      hold_prev = valid && !ready;
      prev_code = code;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    int base;

    // T1: reset with key0 held, then a single press after reset is released.
    rst    = 1'b1;
    enable = 1'b1;
    ready  = 1'b1;
    keys_n = 8'hfe;
    tick(2);
    check("t1_rst_keys_db", keys_db, 8'hff);
    check("t1_rst_valid", valid, 0);
    check("t1_rst_overrun", overrun, 0);
    expect_code(0);
    rst = 1'b0;
    wait_drain("t1_drain");
    tick(4);
    check("t1_no_repeat", valid, 0);
    keys_n = 8'hff;
    tick(10);
    check("t1_release_db", keys_db, 8'hff);

    // T2: exact latency of a single key3 press (edge k = next rising edge).
    keys_n = 8'hf7;
    expect_code(3);
    tick(5);
    check("t2_db_k4", keys_db, 8'hff);
    tick(1);
    check("t2_db_k5", keys_db, 8'hf7);
    tick(1);
    check("t2_valid_k6", valid, 0);
    tick(1);
    check("t2_valid_k7", valid, 1);
    check("t2_code_k7", code, 3);
    tick(1);
    check("t2_valid_k8", valid, 0);
    check("t2_drained", exp_q.size(), 0);
    keys_n = 8'hff;
    tick(12);
    check("t2_release_quiet", valid, 0);

    // T3: key5 low 3 cycles, high 1, low 10 -> a single debounced fall.
    base = db5_falls;
    keys_n = 8'hdf;
    expect_code(5);
    tick(3);
    keys_n = 8'hff;
    tick(1);
    keys_n = 8'hdf;
    tick(10);
    check("t3_db", keys_db, 8'hdf);
    wait_drain("t3_drain");
    keys_n = 8'hff;
    tick(12);
    check("t3_one_fall", db5_falls - base, 1);

    // T4: keys 6 and 2 pressed together while the consumer stalls.
    ready  = 1'b0;
    keys_n = 8'hbb;
    expect_code(2);
    expect_code(6);
    tick(10);
    check("t4_valid", valid, 1);
    check("t4_code_low_first", code, 2);
    ready = 1'b1;
    wait_drain("t4_drain");
    tick(3);
    check("t4_pending_empty", dut.pending, 8'h00);
    keys_n = 8'hff;
    tick(12);

    // T5: re-press of key4 while its code is still held -> overrun.
    base   = overrun_cnt;
    ready  = 1'b0;
    keys_n = 8'hef;
    expect_code(4);
    tick(10);
    check("t5_first_valid", valid, 1);
    keys_n = 8'hff;
    tick(8);
    keys_n = 8'hef;
    tick(10);
    check("t5_overrun_pulses", overrun_cnt - base, 1);
    check("t5_code_held", code, 4);
    ready = 1'b1;
    wait_drain("t5_drain");
    tick(4);
    check("t5_single_delivery", valid, 0);
    keys_n = 8'hff;
    tick(12);

    // T6a: a key1 press while enable is low is debounced but not queued.
    enable = 1'b0;
    keys_n = 8'hfd;
    tick(10);
    check("t6_db_disabled", keys_db, 8'hfd);
    check("t6_no_valid", valid, 0);
    keys_n = 8'hff;
    tick(10);
    enable = 1'b1;
    tick(5);
    check("t6_still_idle", valid, 0);

    // T6b: the re-press of key1 sets pending on the same edge as key1's handshake.
    ready  = 1'b0;
    keys_n = 8'hfd;
    expect_code(1);
    tick(10);
    check("t6_hold_code", code, 1);
    keys_n = 8'hff;
    tick(10);
    base   = overrun_cnt;
    keys_n = 8'hfd;
    expect_code(1);
    tick(6);
    ready = 1'b1;  // handshake lands on edge k+6, the same edge that sets pending
    wait_drain("t6_set_wins_drain");
    check("t6_no_overrun", overrun_cnt - base, 0);
    tick(4);
    check("t6_final_idle", valid, 0);
    keys_n = 8'hff;
    tick(10);

    check("total_handshakes", handshakes, pushes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
